// File: rtl/bsg_manycore_stat_tag_decoder.sv
// bsg_manycore_stat_tag_decoder
//
// Decodes vanilla-core print-stat tag words into records for a profiler back end.
// Start and end words are paired per tag (16 tags). Each matched end reports the
// elapsed cycles since its start. Every accepted word produces one registered
// record with an error code. The output stage is a single valid/ready register,
// so a word accepted on an edge appears as a record right after that edge.
//
// Ports
//   clk_i            clock
//   reset_n_i        asynchronous active-low reset
//   v_i / tag_i      incoming tag word and its valid
//   ready_o          word can be accepted this cycle (~v_o | ready_i)
//   v_o / ready_i    record valid / downstream accepts record
//   stat_type_o      0 stat, 1 start, 2 end, 3 illegal
//   y_cord_o         tile y coordinate
//   x_cord_o         tile x coordinate
//   tile_group_id_o  tile-group id
//   tag_o            programmer tag
//   duration_o       end minus start timestamp (matched or mismatched-tile end only)
//   err_o            0 none, 1 illegal, 2 end w/o start, 3 double start, 4 tile mismatch
//   open_mask_o      bit t set while tag t is open
module bsg_manycore_stat_tag_decoder #(
  parameter int cycle_width_p = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  input  logic [31:0]              tag_i,
  output logic                     ready_o,
  output logic                     v_o,
  input  logic                     ready_i,
  output logic [1:0]               stat_type_o,
  output logic [5:0]               y_cord_o,
  output logic [5:0]               x_cord_o,
  output logic [13:0]              tile_group_id_o,
  output logic [3:0]               tag_o,
  output logic [cycle_width_p-1:0] duration_o,
  output logic [2:0]               err_o,
  output logic [15:0]              open_mask_o
);

  // Output record register
  logic                     v_q;
  logic [1:0]               type_q;
  logic [5:0]               y_q;
  logic [5:0]               x_q;
  logic [13:0]              tg_q;
  logic [3:0]               tag_q;
  logic [cycle_width_p-1:0] dur_q;
  logic [2:0]               err_q;

  // Free-running timestamp source and the per-tag table
  logic [cycle_width_p-1:0] cnt_q;
  logic [15:0]              open_q;
  logic [15:0]              open_d;
  logic [cycle_width_p-1:0] start_q [16];
  logic [5:0]               oy_q    [16];
  logic [5:0]               ox_q    [16];

  // Decoded fields of the incoming word
  logic [1:0]               type_s;
  logic [5:0]               y_s;
  logic [5:0]               x_s;
  logic [13:0]              tg_s;
  logic [3:0]               idx_s;
  logic                     accept_s;
  logic                     wr_start_s;
  logic                     same_tile_s;
  logic [cycle_width_p-1:0] elapsed_s;
  logic [cycle_width_p-1:0] dur_d;
  logic [2:0]               err_d;

  assign type_s   = tag_i[31:30];
  assign y_s      = tag_i[29:24];
  assign x_s      = tag_i[23:18];
  assign tg_s     = tag_i[17:4];
  assign idx_s    = tag_i[3:0];

  // A new word is taken when the output slot is empty or is being drained.
  assign ready_o  = ~v_q | ready_i;
  assign accept_s = v_i & ready_o;

  // Unsigned subtraction at the counter width wraps correctly across rollover.
  assign elapsed_s   = cnt_q - start_q[idx_s];
  assign same_tile_s = (ox_q[idx_s] == x_s) && (oy_q[idx_s] == y_s);

  // Table transition and record contents for the word being accepted
  always_comb begin
    open_d     = open_q;
    wr_start_s = 1'b0;
    dur_d      = '0;
    err_d      = 3'd0;
    if (accept_s) begin
      case (type_s)
        2'd0: begin
          err_d = 3'd0;
        end
        2'd1: begin
          // A restart overwrites the timestamp and tile but keeps the tag open.
          wr_start_s    = 1'b1;
          open_d[idx_s] = 1'b1;
          err_d         = open_q[idx_s] ? 3'd3 : 3'd0;
        end
        2'd2: begin
          if (open_q[idx_s]) begin
            // A tile mismatch still closes the tag and reports the duration.
            dur_d         = elapsed_s;
            open_d[idx_s] = 1'b0;
            err_d         = same_tile_s ? 3'd0 : 3'd4;
          end else begin
            err_d = 3'd2;
          end
        end
        2'd3: begin
          err_d = 3'd1;
        end
        default: begin
          err_d = 3'd1;
        end
      endcase
    end else begin
      open_d = open_q;
    end
  end

  // Per-tag start timestamp and opening tile
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < 16; i++) begin
        start_q[i] <= '0;
        oy_q[i]    <= 6'd0;
        ox_q[i]    <= 6'd0;
      end
    end else if (wr_start_s) begin
      start_q[idx_s] <= cnt_q;
      oy_q[idx_s]    <= y_s;
      ox_q[idx_s]    <= x_s;
    end
  end

  // Counter, open bits and output record register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q  <= '0;
      open_q <= 16'd0;
      v_q    <= 1'b0;
      type_q <= 2'd0;
      y_q    <= 6'd0;
      x_q    <= 6'd0;
      tg_q   <= 14'd0;
      tag_q  <= 4'd0;
      dur_q  <= '0;
      err_q  <= 3'd0;
    end else begin
      cnt_q  <= cnt_q + cycle_width_p'(1);
      open_q <= open_d;
      if (accept_s) begin
        v_q    <= 1'b1;
        type_q <= type_s;
        y_q    <= y_s;
        x_q    <= x_s;
        tg_q   <= tg_s;
        tag_q  <= idx_s;
        dur_q  <= dur_d;
        err_q  <= err_d;
      end else if (ready_i) begin
        v_q <= 1'b0;
      end
    end
  end

  assign v_o             = v_q;
  assign stat_type_o     = type_q;
  assign y_cord_o        = y_q;
  assign x_cord_o        = x_q;
  assign tile_group_id_o = tg_q;
  assign tag_o           = tag_q;
  assign duration_o      = dur_q;
  assign err_o           = err_q;
  assign open_mask_o     = open_q;

endmodule

// File: tb/tb_bsg_manycore_stat_tag_decoder.sv
module tb_bsg_manycore_stat_tag_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        v_i, ready_i, ready_o, v_o;
  logic [31:0] tag_i;
  logic [1:0]  st_o;
  logic [5:0]  y_o, x_o;
  logic [13:0] tg_o;
  logic [3:0]  tag_o;
  logic [31:0] dur_o;
  logic [2:0]  err_o;
  logic [15:0] mask_o;

  logic        v8, ready8_o, v8_o;
  logic [31:0] tag8;
  logic [1:0]  st8;
  logic [5:0]  y8, x8;
  logic [13:0] tg8;
  logic [3:0]  tagn8;
  logic [7:0]  dur8;
  logic [2:0]  err8;
  logic [15:0] mask8;

  bsg_manycore_stat_tag_decoder #(.cycle_width_p(32)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i), .tag_i(tag_i), .ready_o(ready_o),
    .v_o(v_o), .ready_i(ready_i), .stat_type_o(st_o), .y_cord_o(y_o), .x_cord_o(x_o),
    .tile_group_id_o(tg_o), .tag_o(tag_o), .duration_o(dur_o), .err_o(err_o),
    .open_mask_o(mask_o));

  bsg_manycore_stat_tag_decoder #(.cycle_width_p(8)) dut8 (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v8), .tag_i(tag8), .ready_o(ready8_o),
    .v_o(v8_o), .ready_i(1'b1), .stat_type_o(st8), .y_cord_o(y8), .x_cord_o(x8),
    .tile_group_id_o(tg8), .tag_o(tagn8), .duration_o(dur8), .err_o(err8),
    .open_mask_o(mask8));

  // Cycles elapsed since reset release: the timestamp the spec defines.
  longint tcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt <= 0;
    else        tcnt <= tcnt + 1;
  end

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          m_open  [16];
  longint      m_start [16];
  logic [5:0]  m_x     [16];
  logic [5:0]  m_y     [16];

  logic [1:0]  e_ty;
  logic [5:0]  e_y, e_x;
  logic [13:0] e_tg;
  logic [3:0]  e_tag;
  logic [31:0] e_dur;
  logic [2:0]  e_err;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_mask();
    logic [15:0] m;
    for (int i = 0; i < 16; i++) m[i] = m_open[i];
    return m;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_open[i] = 1'b0; m_start[i] = 0; m_x[i] = 6'd0; m_y[i] = 6'd0;
    end
  endtask

  // Apply the decoding rules to word w accepted at timestamp ts.
  task automatic model(input logic [31:0] w, input longint ts);
    int t;
    e_ty = w[31:30]; e_y = w[29:24]; e_x = w[23:18]; e_tg = w[17:4]; e_tag = w[3:0];
    t = int'(w[3:0]);
    e_dur = 32'd0; e_err = 3'd0;
    if (e_ty == 2'd1) begin
      e_err = m_open[t] ? 3'd3 : 3'd0;
      m_open[t] = 1'b1; m_start[t] = ts; m_x[t] = e_x; m_y[t] = e_y;
    end else if (e_ty == 2'd2) begin
      if (m_open[t]) begin
        e_dur = 32'((ts - m_start[t]) % 64'h1_0000_0000);
        e_err = (m_x[t] == e_x && m_y[t] == e_y) ? 3'd0 : 3'd4;
        m_open[t] = 1'b0;
      end else begin
        e_err = 3'd2;
      end
    end else if (e_ty == 2'd3) begin
      e_err = 3'd1;
    end
  endtask

  task automatic check_rec();
    chk("v_o", 64'(v_o), 64'd1);
    chk("stat_type", 64'(st_o), 64'(e_ty));
    chk("y_cord", 64'(y_o), 64'(e_y));
    chk("x_cord", 64'(x_o), 64'(e_x));
    chk("tile_group", 64'(tg_o), 64'(e_tg));
    chk("tag", 64'(tag_o), 64'(e_tag));
    chk("duration", 64'(dur_o), 64'(e_dur));
    chk("err", 64'(err_o), 64'(e_err));
    chk("open_mask", 64'(mask_o), 64'(m_mask()));
  endtask

  task automatic send(input logic [31:0] w);
    @(negedge clk);
    v_i = 1'b1; tag_i = w; ready_i = 1'b1; v8 = 1'b0;
    model(w, tcnt);
    @(posedge clk); #1;
    check_rec();
  endtask

  task automatic idle();
    @(negedge clk);
    v_i = 1'b0; tag_i = $urandom; ready_i = 1'b1; v8 = 1'b0;
    @(posedge clk); #1;
    chk("idle_v_o", 64'(v_o), 64'd0);
    chk("idle_mask", 64'(mask_o), 64'(m_mask()));
  endtask

  task automatic goto(input longint target, input longint modulus);
    int n = 0;
    while ((tcnt % modulus) != target && n < 2000) begin
      idle();
      n++;
    end
    chk("goto_counter", 64'(tcnt % modulus), 64'(target));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; v_i = 1'b0; v8 = 1'b0; ready_i = 1'b1;
    model_clear();
    #2;
    chk("rst_v_o", 64'(v_o), 64'd0);
    chk("rst_ready_o", 64'(ready_o), 64'd1);
    chk("rst_mask", 64'(mask_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_dur", 64'(dur_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] mk(input logic [1:0] ty, input logic [5:0] y,
                                     input logic [5:0] x, input logic [13:0] tg,
                                     input logic [3:0] tg4);
    return {ty, y, x, tg, tg4};
  endfunction

  logic [31:0] wa, wb;

  initial begin
    rst_n = 1'b0; v_i = 1'b0; tag_i = 32'd0; ready_i = 1'b1; v8 = 1'b0; tag8 = 32'd0;
    model_clear();
    #12;
    chk("init_v_o", 64'(v_o), 64'd0);
    chk("init_ready_o", 64'(ready_o), 64'd1);
    chk("init_stat_type", 64'(st_o), 64'd0);
    chk("init_mask", 64'(mask_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // start tag 5 at 10, end at 110
    goto(10, 64'h1_0000_0000);
    send(mk(2'd1, 6'd2, 6'd3, 14'd7, 4'd5));
    chk("t5_start_err", 64'(err_o), 64'd0);
    chk("t5_mask_open", 64'(mask_o), 64'h0020);
    goto(110, 64'h1_0000_0000);
    send(mk(2'd2, 6'd2, 6'd3, 14'd7, 4'd5));
    chk("t5_duration", 64'(dur_o), 64'd100);
    chk("t5_mask_closed", 64'(mask_o), 64'h0000);

    // end on tag 9 without a start
    send(mk(2'd2, 6'd0, 6'd0, 14'd0, 4'd9));
    chk("t9_err", 64'(err_o), 64'd2);
    chk("t9_dur", 64'(dur_o), 64'd0);

    // double start on tag 1
    do_reset();
    goto(4, 64'h1_0000_0000);
    send(mk(2'd1, 6'd0, 6'd0, 14'd1, 4'd1));
    goto(20, 64'h1_0000_0000);
    send(mk(2'd1, 6'd0, 6'd0, 14'd1, 4'd1));
    chk("t1_restart_err", 64'(err_o), 64'd3);
    goto(50, 64'h1_0000_0000);
    send(mk(2'd2, 6'd0, 6'd0, 14'd1, 4'd1));
    chk("t1_duration", 64'(dur_o), 64'd30);
    chk("t1_err", 64'(err_o), 64'd0);

    // tile mismatch on tag 2
    send(mk(2'd1, 6'd1, 6'd1, 14'd3, 4'd2));
    idle();
    send(mk(2'd2, 6'd1, 6'd4, 14'd3, 4'd2));
    chk("t2_err", 64'(err_o), 64'd4);
    chk("t2_dur", 64'(dur_o), 64'd2);
    chk("t2_mask", 64'(mask_o[2]), 64'd0);

    // random traffic against the model
    for (int i = 0; i < 150; i++) begin
      logic [1:0] rty;
      int r;
      if ($urandom_range(0, 3) == 0) idle();
      r = $urandom_range(0, 9);
      rty = (r < 2) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      send(mk(rty, 6'($urandom_range(0, 1)), 6'($urandom_range(0, 1)),
              14'($urandom_range(0, 16383)), 4'($urandom_range(0, 3))));
    end

    // 8-bit counter wrap
    goto(250, 256);
    @(negedge clk); v_i = 1'b0; v8 = 1'b1; tag8 = mk(2'd1, 6'd5, 6'd6, 14'd9, 4'd0);
    @(posedge clk); #1;
    chk("w8_start_err", 64'(err8), 64'd0);
    @(negedge clk); v8 = 1'b0;
    goto(4, 256);
    @(negedge clk); v8 = 1'b1; tag8 = mk(2'd2, 6'd5, 6'd6, 14'd9, 4'd0);
    @(posedge clk); #1;
    chk("w8_v_o", 64'(v8_o), 64'd1);
    chk("w8_duration", 64'(dur8), 64'd10);
    chk("w8_err", 64'(err8), 64'd0);
    chk("w8_mask", 64'(mask8), 64'd0);
    @(negedge clk); tag8 = 32'hC000_0000;
    @(posedge clk); #1;
    chk("ill_type", 64'(st8), 64'd3);
    chk("ill_err", 64'(err8), 64'd1);
    chk("ill_dur", 64'(dur8), 64'd0);
    chk("ill_fields", 64'({y8, x8, tg8, tagn8}), 64'd0);
    chk("ill_ready", 64'(ready8_o), 64'd1);
    @(negedge clk); v8 = 1'b0;

    // backpressure: A held 5 cycles, then A consumed and B loaded
    wa = mk(2'd0, 6'd7, 6'd8, 14'd100, 4'd3);
    wb = mk(2'd1, 6'd9, 6'd10, 14'd200, 4'd6);
    @(negedge clk);
    v_i = 1'b1; tag_i = wa; ready_i = 1'b0;
    model(wa, tcnt);
    @(posedge clk); #1;
    check_rec();
    chk("bp_ready_low", 64'(ready_o), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v_i = 1'b1; tag_i = wb; ready_i = 1'b0;
      @(posedge clk); #1;
      check_rec();
      chk("bp_hold_ready", 64'(ready_o), 64'd0);
    end
    @(negedge clk);
    ready_i = 1'b1;
    model(wb, tcnt);
    #1;
    chk("bp_ready_rise", 64'(ready_o), 64'd1);
    @(posedge clk); #1;
    check_rec();

    // reset asserted while B is held
    @(negedge clk);
    v_i = 1'b0; ready_i = 1'b0;
    @(posedge clk); #1;
    check_rec();
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("mid_rst_v_o", 64'(v_o), 64'd0);
    chk("mid_rst_mask", 64'(mask_o), 64'd0);
    chk("mid_rst_ready", 64'(ready_o), 64'd1);
    chk("mid_rst_rec", 64'({st_o, y_o, x_o, tg_o, tag_o, err_o}), 64'd0);

    // first accept after release uses timestamp 0
    @(negedge clk);
    rst_n = 1'b1; ready_i = 1'b1; v_i = 1'b1;
    tag_i = mk(2'd1, 6'd1, 6'd1, 14'd4, 4'd4);
    model(tag_i, 0);
    @(posedge clk); #1;
    check_rec();
    goto(7, 64'h1_0000_0000);
    send(mk(2'd2, 6'd1, 6'd1, 14'd4, 4'd4));
    chk("ts0_duration", 64'(dur_o), 64'd7);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
